// File: rtl/dfx_seq_ctrl.sv
// DFX sequencer controller: walks bank1 slots 0..endCnt, issuing and timing one
// DMA command per slot, then writing the slot status/profile back to bank1.
module dfx_seq_ctrl #(
    parameter int BANK1_INDEX_WIDTH   = 2,
    parameter int BANK1_ADDR_WIDTH    = 32,
    parameter int BANK1_SIZE_WIDTH    = 26,
    parameter int BANK1_STATUS_WIDTH  = 2,
    parameter int BANK1_PROFILE_WIDTH = 32,
    parameter int BANK0_STATUS_WIDTH  = 4,
    parameter int BANK0_CNT_WIDTH     = BANK1_INDEX_WIDTH
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           ctrl_start,
    input  logic                           ctrl_abort,
    input  logic [BANK0_CNT_WIDTH-1:0]     cfg_endCnt,
    output logic [BANK1_INDEX_WIDTH-1:0]   bank1_rd_index,
    output logic                           bank1_rd_req,
    input  logic                           bank1_rd_ready,
    input  logic [BANK1_ADDR_WIDTH-1:0]    bank1_rd_src_addr,
    input  logic [BANK1_ADDR_WIDTH-1:0]    bank1_rd_des_addr,
    input  logic [BANK1_SIZE_WIDTH-1:0]    bank1_rd_src_size,
    input  logic [BANK1_SIZE_WIDTH-1:0]    bank1_rd_des_size,
    output logic                           bank1_wr_en,
    output logic [BANK1_INDEX_WIDTH-1:0]   bank1_wr_index,
    output logic [BANK1_STATUS_WIDTH-1:0]  bank1_wr_status,
    output logic [BANK1_PROFILE_WIDTH-1:0] bank1_wr_profile,
    output logic                           dma_cmd_valid,
    input  logic                           dma_cmd_ready,
    output logic [BANK1_ADDR_WIDTH-1:0]    dma_src_addr,
    output logic [BANK1_ADDR_WIDTH-1:0]    dma_des_addr,
    output logic [BANK1_SIZE_WIDTH-1:0]    dma_src_size,
    output logic [BANK1_SIZE_WIDTH-1:0]    dma_des_size,
    input  logic                           dma_done,
    input  logic                           dma_err,
    output logic [BANK0_STATUS_WIDTH-1:0]  out_status,
    output logic [BANK0_CNT_WIDTH-1:0]     out_mainCnt,
    output logic [BANK0_CNT_WIDTH-1:0]     out_endCnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_ISSUE  = 3'd2,
        S_WAIT   = 3'd3,
        S_WRBACK = 3'd4
    } state_t;

    localparam logic [BANK0_STATUS_WIDTH-1:0] ST_BUSY  = BANK0_STATUS_WIDTH'(4'b0001);
    localparam logic [BANK0_STATUS_WIDTH-1:0] ST_DONE  = BANK0_STATUS_WIDTH'(4'b0010);
    localparam logic [BANK0_STATUS_WIDTH-1:0] ST_ERR   = BANK0_STATUS_WIDTH'(4'b0100);
    localparam logic [BANK0_STATUS_WIDTH-1:0] ST_ABORT = BANK0_STATUS_WIDTH'(4'b1000);

    state_t                           r_state;
    state_t                           w_next_state;
    logic [BANK0_CNT_WIDTH-1:0]       r_main_cnt;
    logic [BANK0_CNT_WIDTH-1:0]       r_end_cnt;
    logic [BANK0_STATUS_WIDTH-1:0]    r_status;
    logic [BANK1_ADDR_WIDTH-1:0]      r_src_addr;
    logic [BANK1_ADDR_WIDTH-1:0]      r_des_addr;
    logic [BANK1_SIZE_WIDTH-1:0]      r_src_size;
    logic [BANK1_SIZE_WIDTH-1:0]      r_des_size;
    logic [BANK1_PROFILE_WIDTH-1:0]   r_profile;
    logic                             r_err;
    logic                             r_abort_pend;
    logic                             r_wr_en;
    logic [BANK1_INDEX_WIDTH-1:0]     r_wr_index;
    logic [BANK1_STATUS_WIDTH-1:0]    r_wr_status;
    logic [BANK1_PROFILE_WIDTH-1:0]   r_wr_profile;

    logic                             w_abort_any;
    logic                             w_last;
    logic [BANK1_PROFILE_WIDTH-1:0]   w_profile_inc;

    assign w_abort_any   = r_abort_pend | ctrl_abort;
    assign w_last        = r_err | w_abort_any | (r_main_cnt == r_end_cnt);
    assign w_profile_inc = (&r_profile) ? r_profile
                                        : r_profile + BANK1_PROFILE_WIDTH'(1);

    assign bank1_rd_req     = (r_state == S_FETCH);
    assign bank1_rd_index   = BANK1_INDEX_WIDTH'(r_main_cnt);
    assign dma_cmd_valid    = (r_state == S_ISSUE);
    assign dma_src_addr     = r_src_addr;
    assign dma_des_addr     = r_des_addr;
    assign dma_src_size     = r_src_size;
    assign dma_des_size     = r_des_size;
    assign bank1_wr_en      = r_wr_en;
    assign bank1_wr_index   = r_wr_index;
    assign bank1_wr_status  = r_wr_status;
    assign bank1_wr_profile = r_wr_profile;
    assign out_status       = r_status;
    assign out_mainCnt      = r_main_cnt;
    assign out_endCnt       = r_end_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    // A handshake coinciding with an abort in ISSUE still commits the command;
    // the abort then becomes pending and the transfer is written back.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (ctrl_start) w_next_state = S_FETCH;
            S_FETCH: begin
                if (ctrl_abort)          w_next_state = S_IDLE;
                else if (bank1_rd_ready) w_next_state = S_ISSUE;
            end
            S_ISSUE: begin
                if (dma_cmd_ready)       w_next_state = S_WAIT;
                else if (ctrl_abort)     w_next_state = S_IDLE;
            end
            S_WAIT:   if (dma_done) w_next_state = S_WRBACK;
            S_WRBACK: w_next_state = w_last ? S_IDLE : S_FETCH;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_main_cnt   <= '0;
            r_end_cnt    <= '0;
            r_status     <= '0;
            r_src_addr   <= '0;
            r_des_addr   <= '0;
            r_src_size   <= '0;
            r_des_size   <= '0;
            r_profile    <= '0;
            r_err        <= 1'b0;
            r_abort_pend <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_index   <= '0;
            r_wr_status  <= '0;
            r_wr_profile <= '0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (ctrl_start) begin
                        r_main_cnt   <= '0;
                        r_end_cnt    <= cfg_endCnt;
                        r_status     <= ST_BUSY;
                        r_abort_pend <= 1'b0;
                        r_err        <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (ctrl_abort) begin
                        r_status <= ST_ABORT;
                    end else if (bank1_rd_ready) begin
                        r_src_addr   <= bank1_rd_src_addr;
                        r_des_addr   <= bank1_rd_des_addr;
                        r_src_size   <= bank1_rd_src_size;
                        r_des_size   <= bank1_rd_des_size;
                        r_wr_en      <= 1'b1;
                        r_wr_index   <= BANK1_INDEX_WIDTH'(r_main_cnt);
                        r_wr_status  <= BANK1_STATUS_WIDTH'(2'b01);
                        r_wr_profile <= '0;
                    end
                end
                S_ISSUE: begin
                    if (dma_cmd_ready) begin
                        r_profile <= '0;
                        if (ctrl_abort) r_abort_pend <= 1'b1;
                    end else if (ctrl_abort) begin
                        r_status <= ST_ABORT;
                    end
                end
                S_WAIT: begin
                    r_profile <= w_profile_inc;
                    if (ctrl_abort) r_abort_pend <= 1'b1;
                    if (dma_done) begin
                        r_err        <= dma_err;
                        r_wr_en      <= 1'b1;
                        r_wr_index   <= BANK1_INDEX_WIDTH'(r_main_cnt);
                        r_wr_status  <= BANK1_STATUS_WIDTH'({1'b1, dma_err});
                        r_wr_profile <= w_profile_inc;
                    end
                end
                S_WRBACK: begin
                    if (r_err)            r_status   <= ST_ERR;
                    else if (w_abort_any) r_status   <= ST_ABORT;
                    else if (w_last)      r_status   <= ST_DONE;
                    else                  r_main_cnt <= r_main_cnt + BANK0_CNT_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dfx_seq_ctrl.sv
// Self-checking bench for dfx_seq_ctrl: randomized descriptors/latencies against a
// transaction-level model of the expected DMA commands, write-backs and final status.
module tb_dfx_seq_ctrl;
    localparam int IW = 2;
    localparam int AW = 32;
    localparam int SW = 26;
    localparam int PW = 32;
    localparam int NS = 1 << IW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          ctrl_start = 1'b0;
    logic          ctrl_abort = 1'b0;
    logic [IW-1:0] cfg_endCnt = '0;
    logic [IW-1:0] bank1_rd_index;
    logic          bank1_rd_req;
    logic          bank1_rd_ready = 1'b0;
    logic [AW-1:0] bank1_rd_src_addr = '0;
    logic [AW-1:0] bank1_rd_des_addr = '0;
    logic [SW-1:0] bank1_rd_src_size = '0;
    logic [SW-1:0] bank1_rd_des_size = '0;
    logic          bank1_wr_en;
    logic [IW-1:0] bank1_wr_index;
    logic [1:0]    bank1_wr_status;
    logic [PW-1:0] bank1_wr_profile;
    logic          dma_cmd_valid;
    logic          dma_cmd_ready = 1'b0;
    logic [AW-1:0] dma_src_addr, dma_des_addr;
    logic [SW-1:0] dma_src_size, dma_des_size;
    logic          dma_done = 1'b0;
    logic          dma_err = 1'b0;
    logic [3:0]    out_status;
    logic [IW-1:0] out_mainCnt, out_endCnt;

    typedef struct {
        int            idx;
        logic [1:0]    st;
        logic [PW-1:0] prof;
    } wb_t;

    wb_t           exp_wb[$];
    int            exp_cmd[$];
    logic [AW-1:0] mem_src[NS];
    logic [AW-1:0] mem_des[NS];
    logic [SW-1:0] mem_ssz[NS];
    logic [SW-1:0] mem_dsz[NS];
    int            dly[NS];
    int            checks = 0;
    int            errors = 0;
    int            err_slot = -1;
    int            fetch_max = 0;
    int            cur_slot = 0;
    int            dly_cnt = 0;
    int            hs_cnt = 0;
    int            exp_main = 0;
    logic [3:0]    exp_status = '0;
    bit            fast = 1'b0;
    bit            hold_cmd = 1'b0;
    bit            force_done = 1'b0;

    dfx_seq_ctrl #(
        .BANK1_INDEX_WIDTH  (IW),
        .BANK1_ADDR_WIDTH   (AW),
        .BANK1_SIZE_WIDTH   (SW),
        .BANK1_STATUS_WIDTH (2),
        .BANK1_PROFILE_WIDTH(PW),
        .BANK0_STATUS_WIDTH (4),
        .BANK0_CNT_WIDTH    (IW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .ctrl_start       (ctrl_start),
        .ctrl_abort       (ctrl_abort),
        .cfg_endCnt       (cfg_endCnt),
        .bank1_rd_index   (bank1_rd_index),
        .bank1_rd_req     (bank1_rd_req),
        .bank1_rd_ready   (bank1_rd_ready),
        .bank1_rd_src_addr(bank1_rd_src_addr),
        .bank1_rd_des_addr(bank1_rd_des_addr),
        .bank1_rd_src_size(bank1_rd_src_size),
        .bank1_rd_des_size(bank1_rd_des_size),
        .bank1_wr_en      (bank1_wr_en),
        .bank1_wr_index   (bank1_wr_index),
        .bank1_wr_status  (bank1_wr_status),
        .bank1_wr_profile (bank1_wr_profile),
        .dma_cmd_valid    (dma_cmd_valid),
        .dma_cmd_ready    (dma_cmd_ready),
        .dma_src_addr     (dma_src_addr),
        .dma_des_addr     (dma_des_addr),
        .dma_src_size     (dma_src_size),
        .dma_des_size     (dma_des_size),
        .dma_done         (dma_done),
        .dma_err          (dma_err),
        .out_status       (out_status),
        .out_mainCnt      (out_mainCnt),
        .out_endCnt       (out_endCnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected traffic for one run: every slot 0..e gets a busy then a final
    // write-back, stopping early at the error slot or the slot aborted in WAIT.
    task automatic build_exp(input int e, input int errs, input int abort_slot);
        exp_wb.delete();
        exp_cmd.delete();
        for (int i = 0; i <= e; i++) begin
            wb_t w;
            exp_cmd.push_back(i);
            w.idx = i; w.st = 2'b01; w.prof = '0;
            exp_wb.push_back(w);
            w.st = (i == errs) ? 2'b11 : 2'b10;
            w.prof = PW'(dly[i]);
            exp_wb.push_back(w);
            fetch_max = i;
            exp_main  = i;
            exp_status = 4'b0010;
            if (i == errs) begin exp_status = 4'b0100; break; end
            if (i == abort_slot) begin exp_status = 4'b1000; break; end
        end
    endtask

    // Bank1/DMA responders and output monitors; inputs change only on negedge.
    always @(negedge clk) begin
        if (bank1_wr_en) begin
            if (exp_wb.size() == 0) begin
                check("wb_unexpected", 1, 0);
            end else begin
                wb_t w;
                w = exp_wb.pop_front();
                check("wb_idx", bank1_wr_index, w.idx);
                check("wb_status", bank1_wr_status, w.st);
                check("wb_profile", bank1_wr_profile, w.prof);
            end
        end
        if (bank1_rd_req)
            check("fetch_idx_in_range", int'(bank1_rd_index) <= fetch_max, 1);

        if (bank1_rd_req && (fast || $urandom_range(0, 2) == 0)) begin
            bank1_rd_ready    = 1'b1;
            bank1_rd_src_addr = mem_src[bank1_rd_index];
            bank1_rd_des_addr = mem_des[bank1_rd_index];
            bank1_rd_src_size = mem_ssz[bank1_rd_index];
            bank1_rd_des_size = mem_dsz[bank1_rd_index];
        end else begin
            bank1_rd_ready    = 1'b0;
            bank1_rd_src_addr = $urandom;
            bank1_rd_des_addr = $urandom;
            bank1_rd_src_size = SW'($urandom);
            bank1_rd_des_size = SW'($urandom);
        end

        dma_done = force_done;
        dma_err  = 1'($urandom_range(0, 1));
        if (dly_cnt > 0) begin
            dly_cnt--;
            if (dly_cnt == 0) begin
                dma_done = 1'b1;
                dma_err  = (cur_slot == err_slot);
            end
        end

        if (dma_cmd_valid)
            dma_cmd_ready = !hold_cmd && (fast || $urandom_range(0, 2) == 0);
        else
            dma_cmd_ready = 1'($urandom_range(0, 1));

        if (dma_cmd_valid && dma_cmd_ready) begin
            if (exp_cmd.size() == 0) begin
                check("cmd_unexpected", 1, 0);
            end else begin
                int s;
                s = exp_cmd.pop_front();
                check("cmd_src_addr", dma_src_addr, mem_src[s]);
                check("cmd_des_addr", dma_des_addr, mem_des[s]);
                check("cmd_src_size", dma_src_size, mem_ssz[s]);
                check("cmd_des_size", dma_des_size, mem_dsz[s]);
                cur_slot = s;
                dly_cnt  = dly[s];
                hs_cnt++;
            end
        end
    end

    task automatic wait_hs(input int n);
        int k = 0;
        do begin @(posedge clk); k++; end while (hs_cnt < n && k < 1000);
        check("hs_reached", hs_cnt >= n, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_status"}, out_status, 4'b0000);
        check({tag, "_main"}, out_mainCnt, 0);
        check({tag, "_end"}, out_endCnt, 0);
        check({tag, "_rd_req"}, bank1_rd_req, 0);
        check({tag, "_wr_en"}, bank1_wr_en, 0);
        check({tag, "_wr_profile"}, bank1_wr_profile, 0);
        check({tag, "_cmd_valid"}, dma_cmd_valid, 0);
        check({tag, "_dma_src"}, dma_src_addr, 0);
    endtask

    // mode 0: plain run plus an ignored start during WAIT of slot 0
    // mode 1: abort during WAIT of slot mslot
    // mode 2: reset during WAIT of slot mslot
    task automatic run(input int e, input int errs, input int mode, input int mslot,
                       input bit fst, input bit both, input int dfix);
        int k = 0;
        @(posedge clk);
        fast     = fst;
        err_slot = errs;
        hs_cnt   = 0;
        for (int i = 0; i < NS; i++) begin
            mem_src[i] = $urandom;
            mem_des[i] = $urandom;
            mem_ssz[i] = SW'($urandom);
            mem_dsz[i] = SW'($urandom);
            dly[i]     = (dfix > 0) ? dfix : int'($urandom_range(1, 6));
        end
        begin
            int z;
            z = int'($urandom_range(0, NS - 1));
            mem_ssz[z] = '0;
            mem_dsz[z] = '0;
        end
        build_exp(e, errs, (mode == 1) ? mslot : -1);
        @(negedge clk);
        cfg_endCnt = IW'(e);
        ctrl_start = 1'b1;
        ctrl_abort = both;
        @(negedge clk);
        ctrl_start = 1'b0;
        ctrl_abort = 1'b0;
        cfg_endCnt = IW'($urandom);
        check("start_status", out_status, 4'b0001);
        check("start_main", out_mainCnt, 0);
        check("start_end", out_endCnt, e);

        if (mode == 0) begin
            wait_hs(1);
            @(negedge clk);
            ctrl_start = 1'b1;
            cfg_endCnt = ~IW'(e);
            @(negedge clk);
            ctrl_start = 1'b0;
        end else if (mode == 1) begin
            wait_hs(mslot + 1);
            @(negedge clk);
            ctrl_abort = 1'b1;
            @(negedge clk);
            ctrl_abort = 1'b0;
        end else begin
            wait_hs(mslot + 1);
            #2 reset = 1'b0;
            #1 check_reset_outputs("async_reset");
            exp_wb.delete();
            exp_cmd.delete();
            dly_cnt = 0;
            @(negedge clk);
            check_reset_outputs("held_reset");
            reset = 1'b1;
            return;
        end

        do begin @(negedge clk); k++; end while (out_status[0] && k < 2000);
        check("run_finished", out_status[0], 0);
        check("final_status", out_status, exp_status);
        check("final_main", out_mainCnt, exp_main);
        check("final_end", out_endCnt, e);
        check("wb_all_seen", exp_wb.size(), 0);
        check("cmd_all_seen", exp_cmd.size(), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b1;
        @(negedge clk);

        @(posedge clk) force_done = 1'b1;
        @(posedge clk) force_done = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("idle_done");

        run(2, -1, 0, 0, 1'b1, 1'b0, 5);
        run(3, 1, 0, 0, 1'b0, 1'b1, 0);
        run(3, -1, 1, 0, 1'b0, 1'b0, 4);

        begin
            int k = 0;
            wb_t w;
            @(posedge clk);
            hold_cmd = 1'b1;
            fast     = 1'b1;
            err_slot = -1;
            exp_wb.delete();
            exp_cmd.delete();
            w.idx = 0; w.st = 2'b01; w.prof = '0;
            exp_wb.push_back(w);
            fetch_max = 0;
            @(negedge clk);
            cfg_endCnt = IW'(3);
            ctrl_start = 1'b1;
            @(negedge clk);
            ctrl_start = 1'b0;
            while (!dma_cmd_valid && k < 100) begin @(negedge clk); k++; end
            check("issue_reached", dma_cmd_valid, 1);
            ctrl_abort = 1'b1;
            @(negedge clk);
            ctrl_abort = 1'b0;
            check("issue_abort_valid", dma_cmd_valid, 0);
            check("issue_abort_status", out_status, 4'b1000);
            check("issue_abort_main", out_mainCnt, 0);
            repeat (2) @(negedge clk);
            check("issue_abort_wb", exp_wb.size(), 0);
            @(posedge clk) hold_cmd = 1'b0;
        end
        run(3, -1, 0, 0, 1'b0, 1'b0, 0);

        run(3, -1, 2, 1, 1'b0, 1'b0, 0);
        run(int'($urandom_range(0, 3)), -1, 0, 0, 1'b0, 1'b0, 0);
        run(0, -1, 0, 0, 1'b1, 1'b0, 0);

        for (int r = 0; r < 6; r++)
            run(int'($urandom_range(0, 3)),
                ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : -1,
                0, 0, 1'($urandom_range(0, 1)), 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
